// File: rtl/count_sched.sv
// Shares the BlackJack counting resource between the card draw (free-running
// 1..CARD_MAX sampler) and the FSM's prescaled two-second delay.
module count_sched #(
    parameter int WIDTH       = 12,
    parameter int CLK_DIV     = 25000,
    parameter int DELAY_TICKS = 4000,
    parameter int CARD_MAX    = 13
) (
    input  logic             clk_50M,
    input  logic             i_Reset_n,
    input  logic             i_DrawReq,
    input  logic             i_DelayReq,
    input  logic             i_Abort,
    output logic             o_DrawAck,
    output logic [3:0]       o_Card,
    output logic             o_TwoSec,
    output logic             o_Busy,
    output logic [WIDTH-1:0] o_Count
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(DELAY_TICKS - 1);
    localparam logic [WIDTH-1:0] CNT_DONE = WIDTH'(DELAY_TICKS);
    localparam logic [3:0]       CARD_TOP = 4'(CARD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    r_Card;
    logic [PW-1:0] prescaler;
    logic          draw_armed;

    // Draw handshake: i_DrawReq is a level held by the requester until the
    // one-cycle o_DrawAck; a fresh request needs one low cycle to re-arm.
    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= IDLE;
            r_Card     <= 4'd1;
            o_Card     <= 4'd0;
            o_DrawAck  <= 1'b0;
            o_TwoSec   <= 1'b0;
            o_Busy     <= 1'b0;
            o_Count    <= '0;
            prescaler  <= '0;
            draw_armed <= 1'b1;
        end else begin
            r_Card    <= (r_Card == CARD_TOP) ? 4'd1 : r_Card + 4'd1;
            o_DrawAck <= 1'b0;
            o_TwoSec  <= 1'b0;
            if (!i_DrawReq) begin
                draw_armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_DrawReq && draw_armed) begin
                        o_Card     <= r_Card;
                        o_DrawAck  <= 1'b1;
                        draw_armed <= 1'b0;
                    end else if (i_DelayReq) begin
                        state     <= DELAY;
                        prescaler <= '0;
                        o_Count   <= '0;
                        o_Busy    <= 1'b1;
                    end
                end

                DELAY: begin
                    // Abort beats a completion landing on the same edge.
                    if (i_Abort) begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end else if (prescaler == PRE_LAST) begin
                        prescaler <= '0;
                        if (o_Count == CNT_LAST) begin
                            o_Count  <= CNT_DONE;
                            state    <= DONE;
                            o_TwoSec <= 1'b1;
                        end else begin
                            o_Count <= o_Count + 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
- Controller that sequences and shares the game's counting resource between two requesters in the BlackJack datapath.
- Requester 1 is the card draw: it samples a free-running 1..CARD_MAX counter as a pseudo-random card value.
- Requester 2 is the FSM's two-second delay: it runs a prescaled tick counter and pulses completion.
- Only one requester owns the resource at a time. The FSM talks only to this block, never to the raw counter.

Parameters:
- WIDTH, 12, width of o_Count; must satisfy 2^WIDTH >= DELAY_TICKS.
- CLK_DIV, 25000, clk_50M cycles per delay tick (2 kHz tick at 50 MHz).
- DELAY_TICKS, 4000, ticks per delay (4000 x 0.5 ms = 2 s).
- CARD_MAX, 13, top card value; range 2..15.

Ports:
- clk_50M  in  1  system clock, 50 MHz, rising edge.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_DrawReq  in  1  level request for one card; hold until o_DrawAck.
- i_DelayReq  in  1  level request to start a two-second delay.
- i_Abort  in  1  cancel a running delay.
- o_DrawAck  out  1  one-cycle pulse; o_Card valid from this cycle.
- o_Card  out  4  sampled card value 1..CARD_MAX; held until next ack.
- o_TwoSec  out  1  one-cycle pulse at delay completion.
- o_Busy  out  1  high while in DELAY or DONE.
- o_Count  out  WIDTH  elapsed ticks of the current or last delay.

Behaviour:
- Reset (async, i_Reset_n=0): state IDLE, r_Card=1, o_Card=0, o_DrawAck=0, o_TwoSec=0, o_Busy=0, o_Count=0, prescaler=0, draw_armed=1.
- Card counter r_Card:
  - Increments every clk_50M edge in all states.
  - Wraps from CARD_MAX to 1; never holds 0.
- State IDLE:
  - If i_DrawReq=1 and draw_armed=1: o_Card<=r_Card (pre-increment value), o_DrawAck=1 next cycle, draw_armed<=0. Stay in IDLE.
  - Else if i_DelayReq=1: go to DELAY, prescaler<=0, o_Count<=0, o_Busy<=1.
  - A valid draw and i_DelayReq in the same cycle: the draw wins. The delay is taken at the first later edge with no valid draw, provided i_DelayReq is still high.
- Draw re-arm: draw_armed<=1 on any edge with i_DrawReq=0. Holding the request high yields exactly one ack.
- State DELAY:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - A tick occurs on the cycle where prescaler==CLK_DIV-1; o_Count increments on that edge.
  - If a tick occurs with o_Count==DELAY_TICKS-1: o_Count<=DELAY_TICKS, go to DONE, o_TwoSec=1.
  - i_Abort=1: go to IDLE, o_Busy<=0, no o_TwoSec, o_Count holds its value. Abort wins over simultaneous completion.
  - Draw requests are not served here; they stay pending, are not lost, and are served in IDLE.
  - i_DelayReq is ignored while in DELAY.
- State DONE: lasts one cycle with o_TwoSec=1, then IDLE, o_Busy<=0.
- Delay timing: i_DelayReq is sampled at edge N.
  - o_TwoSec is high in the cycle after edge N+CLK_DIV*DELAY_TICKS.
  - o_Busy is high from after edge N through the o_TwoSec cycle.
- Restart: if i_DelayReq is still high in IDLE after DONE, a new delay starts. The FSM must drop the request on o_TwoSec.
- All outputs are registered; no combinational input-to-output paths.

Test Plan (CLK_DIV=4, DELAY_TICKS=5, CARD_MAX=13):
- Reset mid-delay: assert i_Reset_n=0 at tick 3 -> all outputs 0 immediately, o_Card=0, r_Card=1; after release, state IDLE.
- Delay: i_DelayReq high 1 cycle at edge N -> o_Busy=1 from N+1; o_Count steps 1..5 at edges N+4,8,12,16,20; o_TwoSec=1 only in cycle after N+20; o_Busy=0 after N+21.
- Draw: i_DrawReq held high 10 cycles starting 3 edges after reset -> exactly one o_DrawAck; o_Card=4. Then drop for 1 cycle and raise 13 cycles later -> o_Card same value mod 13 (wrap 13->1 checked).
- Conflict: i_DrawReq and i_DelayReq rise together in IDLE -> ack first; delay starts on the next edge; total o_TwoSec latency = 21 edges from the request.
- Abort: i_Abort at cycle of 5th tick -> no o_TwoSec, IDLE, o_Count=4; a draw held during DELAY acks 1 cycle after abort.
